pipeline_hazard_ctrl: RTL and testbench

- Sequences the IF/ID and ID/EX pipeline buffers and the PC register.
- Inserts load-use stalls (bubbles into ID/EX while holding PC and IF/ID).
- Flushes the wrong-path instructions on a taken branch or jump.
- Honours a global hold from the memory system and keeps saturating stall and flush counters for debug.

---
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes and global hold
// for the PC, IF/ID and ID/EX registers, plus saturating debug counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W   = 6,
  parameter int LOAD_STALL   = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memRead_ex,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic                  use_rs_id,
  input  logic                  use_rt_id,
  input  logic                  redirect,
  input  logic                  hold,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_en,
  output logic                  idex_flush,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  if (LOAD_STALL < 1 || LOAD_STALL > 15) begin : g_bad_load_stall
    $error("LOAD_STALL must be in 1..15");
  end
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
    $error("FLUSH_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    ILL   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             haz;

  assign haz = memRead_ex & ((use_rs_id & (rs_id == rd_ex)) |
                             (use_rt_id & (rt_id == rd_ex)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_d    = stall_q;
    flush_d    = flush_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    if (reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
      cnt_d      = '0;
      stall_d    = '0;
      flush_d    = '0;
    end else if (hold) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_en = 1'b0;
    end else if (redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      if (flush_q != '1) flush_d = flush_q + 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = 4'(FLUSH_CYCLES - 2);
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (haz) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            if (stall_q != '1) stall_d = stall_q + 1'b1;
            if (LOAD_STALL > 1) begin
              state_d = STALL;
              cnt_d   = 4'(LOAD_STALL - 2);
            end
          end
        end
        STALL: begin
          // haz deliberately ignored here: the bubble count was fixed on entry
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          if (stall_q != '1) stall_d = stall_q + 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        FLUSH: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    stall_q <= stall_d;
    flush_q <= flush_d;
  end

  assign state_o      = state_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl: three parameterisations share the
// same stimulus and are compared against a remaining-cycles reference model.
module tb_pipeline_hazard_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, memRead_ex, redirect, hold, use_rs_id, use_rt_id;
  logic [5:0] rd_ex, rs_id, rt_id;
  logic [2:0] pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic [1:0] st0, st1, st2;
  logic [15:0] sc0, sc1, fe0, fe1;
  logic [1:0]  sc2, fe2;

  pipeline_hazard_ctrl #(.REG_ADDR_W(6), .LOAD_STALL(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .memRead_ex(memRead_ex), .rd_ex(rd_ex), .rs_id(rs_id),
    .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .redirect(redirect),
    .hold(hold), .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .ifid_flush(ifid_flush[0]),
    .idex_en(idex_en[0]), .idex_flush(idex_flush[0]), .state_o(st0),
    .stall_cycles(sc0), .flush_events(fe0));

  pipeline_hazard_ctrl #(.REG_ADDR_W(6), .LOAD_STALL(3), .FLUSH_CYCLES(2), .CNT_W(16)) dut_b (
    .clock(clock), .reset(reset), .memRead_ex(memRead_ex), .rd_ex(rd_ex), .rs_id(rs_id),
    .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .redirect(redirect),
    .hold(hold), .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .ifid_flush(ifid_flush[1]),
    .idex_en(idex_en[1]), .idex_flush(idex_flush[1]), .state_o(st1),
    .stall_cycles(sc1), .flush_events(fe1));

  pipeline_hazard_ctrl #(.REG_ADDR_W(6), .LOAD_STALL(3), .FLUSH_CYCLES(2), .CNT_W(2)) dut_c (
    .clock(clock), .reset(reset), .memRead_ex(memRead_ex), .rd_ex(rd_ex), .rs_id(rs_id),
    .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .redirect(redirect),
    .hold(hold), .pc_en(pc_en[2]), .ifid_en(ifid_en[2]), .ifid_flush(ifid_flush[2]),
    .idex_en(idex_en[2]), .idex_flush(idex_flush[2]), .state_o(st2),
    .stall_cycles(sc2), .flush_events(fe2));

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned ls   [3] = '{1, 3, 3};
  int unsigned fc   [3] = '{1, 2, 2};
  int unsigned cmax [3] = '{65535, 65535, 3};

  // Model: bubbles / flush cycles still owed after the current one, and counters.
  int unsigned stall_rem [3];
  int unsigned flush_rem [3];
  int unsigned stalls    [3];
  int unsigned flushes   [3];
  bit          known = 1'b0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned dut_state(input int i);
    return (i == 0) ? int'(st0) : (i == 1) ? int'(st1) : int'(st2);
  endfunction
  function automatic int unsigned dut_stalls(input int i);
    return (i == 0) ? int'(sc0) : (i == 1) ? int'(sc1) : int'(sc2);
  endfunction
  function automatic int unsigned dut_flushes(input int i);
    return (i == 0) ? int'(fe0) : (i == 1) ? int'(fe1) : int'(fe2);
  endfunction

  task automatic cyc(input bit r, input bit h, input bit rdr, input bit mr,
                     input logic [5:0] d, input logic [5:0] s, input logic [5:0] t,
                     input bit ur, input bit ut);
    bit haz;
    bit e_pc, e_ifid, e_idex, e_iff, e_idf;
    int unsigned code;
    @(negedge clock);
    reset = r; hold = h; redirect = rdr; memRead_ex = mr;
    rd_ex = d; rs_id = s; rt_id = t; use_rs_id = ur; use_rt_id = ut;
    #1;
    haz = mr && ((ur && s == d) || (ut && t == d));
    for (int i = 0; i < 3; i++) begin
      code = (stall_rem[i] > 0) ? 1 : (flush_rem[i] > 0) ? 2 : 0;
      if (known) begin
        check($sformatf("state_o[%0d]", i), dut_state(i), code);
        check($sformatf("stall_cycles[%0d]", i), dut_stalls(i), stalls[i]);
        check($sformatf("flush_events[%0d]", i), dut_flushes(i), flushes[i]);
      end
      e_pc = 1; e_ifid = 1; e_idex = 1; e_iff = 0; e_idf = 0;
      if (r) begin
        e_pc = 0; e_ifid = 0; e_idex = 0; e_iff = 1; e_idf = 1;
        stall_rem[i] = 0; flush_rem[i] = 0; stalls[i] = 0; flushes[i] = 0;
      end else if (h) begin
        e_pc = 0; e_ifid = 0; e_idex = 0;
      end else if (rdr) begin
        e_iff = 1; e_idf = 1;
        if (flushes[i] < cmax[i]) flushes[i]++;
        stall_rem[i] = 0;
        flush_rem[i] = fc[i] - 1;
      end else if (stall_rem[i] > 0 || (flush_rem[i] == 0 && haz)) begin
        e_pc = 0; e_ifid = 0; e_idf = 1;
        if (stalls[i] < cmax[i]) stalls[i]++;
        stall_rem[i] = (stall_rem[i] > 0) ? stall_rem[i] - 1 : ls[i] - 1;
      end else if (flush_rem[i] > 0) begin
        e_iff = 1; e_idf = 1;
        flush_rem[i]--;
      end
      check($sformatf("pc_en[%0d]", i), int'(pc_en[i]), int'(e_pc));
      check($sformatf("ifid_en[%0d]", i), int'(ifid_en[i]), int'(e_ifid));
      check($sformatf("idex_en[%0d]", i), int'(idex_en[i]), int'(e_idex));
      check($sformatf("ifid_flush[%0d]", i), int'(ifid_flush[i]), int'(e_iff));
      check($sformatf("idex_flush[%0d]", i), int'(idex_flush[i]), int'(e_idf));
    end
    if (r) known = 1'b1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) cyc(0, 0, 0, 0, 6'd1, 6'd2, 6'd3, 0, 0);
  endtask

  task automatic hazard_rs();
    cyc(0, 0, 0, 1, 6'd5, 6'd5, 6'd0, 1, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      stall_rem[i] = 0; flush_rem[i] = 0; stalls[i] = 0; flushes[i] = 0;
    end
    // reset and quiet run
    cyc(1, 0, 0, 0, 6'd0, 6'd0, 6'd0, 0, 0);
    cyc(1, 0, 0, 0, 6'd0, 6'd0, 6'd0, 0, 0);
    idle(3);
    // load-use on rs, then a non-hazard with use flags cleared
    hazard_rs();
    idle(4);
    cyc(0, 0, 0, 1, 6'd5, 6'd7, 6'd5, 0, 0);
    cyc(0, 0, 0, 1, 6'd0, 6'd9, 6'd0, 0, 1);
    idle(4);
    // redirect pulse, then redirect again in the flush cycle
    cyc(0, 0, 1, 0, 6'd0, 6'd1, 6'd2, 0, 0);
    idle(3);
    cyc(0, 0, 1, 0, 6'd0, 6'd1, 6'd2, 0, 0);
    cyc(0, 0, 1, 0, 6'd0, 6'd1, 6'd2, 0, 0);
    idle(3);
    // redirect aborting a stall, and redirect beating a simultaneous hazard
    hazard_rs();
    cyc(0, 0, 1, 0, 6'd0, 6'd1, 6'd2, 0, 0);
    idle(3);
    cyc(0, 0, 1, 1, 6'd5, 6'd5, 6'd0, 1, 0);
    idle(3);
    // hold mid-stall with redirect/haz pending, then counter saturation
    hazard_rs();
    for (int k = 0; k < 4; k++) cyc(0, 1, k[0], 1, 6'd5, 6'd5, 6'd5, 1, 1);
    idle(4);
    hazard_rs();
    idle(2);
    hazard_rs();
    idle(4);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, 6'd0, 6'd0, 6'd0, 0, 0);
    idle(3);
    // randomized traffic
    cyc(1, 0, 0, 0, 6'd0, 6'd0, 6'd0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
          6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
